// File: rtl/tt_check_pkg.sv
// Shared types and default sizes for the truth-table sweep checker.
package tt_check_pkg;

    localparam int unsigned N_IN_DFLT   = 3;
    localparam int unsigned SETTLE_DFLT = 1;
    localparam int unsigned VEC_W       = N_IN_DFLT;
    localparam int unsigned TBL_W       = 1 << VEC_W;
    localparam int unsigned SETTLE_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/tt_vec_sequencer.sv
// Input-vector counter plus settle counter; strobes for exactly one cycle per vector.
module tt_vec_sequencer
    import tt_check_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DFLT,
    parameter int unsigned SETTLE = SETTLE_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            wait_en,
    output logic [N_IN-1:0] vec_out,
    output logic            cmp_strobe,
    output logic            settle_hit_c,
    output logic            last_vec_c
);

    logic [SETTLE_W-1:0] settle_cnt;

    assign settle_hit_c = (settle_cnt == SETTLE_W'(SETTLE - 1));
    assign last_vec_c   = &vec_out;

    // Strobe marks the compare cycle; the vector only advances when leaving it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_out    <= '0;
            settle_cnt <= '0;
            cmp_strobe <= 1'b0;
        end else if (clr) begin
            vec_out    <= '0;
            settle_cnt <= '0;
            cmp_strobe <= 1'b0;
        end else if (cmp_strobe) begin
            cmp_strobe <= 1'b0;
            if (!last_vec_c) begin
                vec_out    <= vec_out + N_IN'(1);
                settle_cnt <= '0;
            end
        end else if (wait_en) begin
            if (settle_hit_c) begin
                cmp_strobe <= 1'b1;
            end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
        end
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector through a reference and a minimized function and compares them.
module tt_sweep_checker
    import tt_check_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DFLT,
    parameter int unsigned SETTLE = SETTLE_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 f_ref,
    input  logic                 f_min,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 equiv,
    output logic [(1<<N_IN)-1:0] ref_table,
    output logic [(1<<N_IN)-1:0] mismatch_mask,
    output logic [N_IN:0]        fail_count,
    output logic [N_IN-1:0]      first_fail
);

    localparam int unsigned FC_W = N_IN + 1;

    state_t state;
    state_t state_nxt;
    logic   start_acc_c;
    logic   miss_c;
    logic   cmp_strobe;
    logic   settle_hit_c;
    logic   last_vec_c;

    tt_vec_sequencer #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .clr          (start_acc_c),
        .wait_en      (state == WAIT),
        .vec_out      (vec_out),
        .cmp_strobe   (cmp_strobe),
        .settle_hit_c (settle_hit_c),
        .last_vec_c   (last_vec_c)
    );

    assign miss_c = f_ref ^ f_min;

    // Next-state logic; start is only honoured while not sweeping.
    always_comb begin
        state_nxt   = state;
        start_acc_c = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_acc_c = 1'b1;
                    state_nxt   = WAIT;
                end
            end
            WAIT:    if (settle_hit_c) state_nxt = CMP;
            CMP:     state_nxt = last_vec_c ? DONE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            equiv         <= 1'b0;
            ref_table     <= '0;
            mismatch_mask <= '0;
            fail_count    <= '0;
            first_fail    <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == WAIT) || (state_nxt == CMP);
            done  <= (state_nxt == DONE);
            if (start_acc_c) begin
                equiv         <= 1'b0;
                ref_table     <= '0;
                mismatch_mask <= '0;
                fail_count    <= '0;
                first_fail    <= '0;
            end else if (cmp_strobe) begin
                ref_table[vec_out]     <= f_ref;
                mismatch_mask[vec_out] <= miss_c;
                if (miss_c) begin
                    fail_count <= fail_count + FC_W'(1);
                    if (fail_count == FC_W'(0)) first_fail <= vec_out;
                end
                // Verdict includes the final vector's own compare result.
                if (last_vec_c) equiv <= (fail_count == FC_W'(0)) && !miss_c;
            end
        end
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Sequential truth-table sweeper and equivalence checker for the combinational minimization blocks (reference SOP function vs. minimized function).
- Drives every input vector {A,B,C,...} to both functions, waits a settle time, then samples and compares the two outputs.
- Reports the captured reference truth table, a per-vector mismatch mask, a fail count, the first failing vector, and a final equivalence verdict.
- Replaces the hand-written stimulus/$monitor bench with a self-checking, synthesizable stage.

Parameters:
- N_IN, default 3: number of function inputs; legal range 1..6.
- SETTLE, default 1: cycles each vector is held before the compare cycle; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a sweep; one-cycle pulse or level.
- f_ref  in  1  output of the reference (canonical SOP) function.
- f_min  in  1  output of the minimized function.
- vec_out  out  N_IN  current input vector; MSB = A, LSB = last input.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; results valid.
- equiv  out  1  1 when done and no mismatch occurred.
- ref_table  out  2**N_IN  bit i = f_ref sampled at vector i.
- mismatch_mask  out  2**N_IN  bit i = (f_ref != f_min) at vector i.
- fail_count  out  N_IN+1  number of mismatching vectors.
- first_fail  out  N_IN  index of the lowest mismatching vector; 0 if none.

Behaviour:
- Reset (asynchronous, immediate) forces all outputs to 0 and the state to IDLE.
- States are IDLE, WAIT, CMP and DONE.
- IDLE:
  - busy=0, vec_out=0.
  - start=1 at edge k: clear ref_table, mismatch_mask, fail_count and first_fail; set vec_out=0 and the settle counter to 0; go to WAIT.
- WAIT:
  - busy=1; vec_out held.
  - Counter increments each cycle; when it equals SETTLE-1, go to CMP. WAIT therefore lasts exactly SETTLE cycles.
- CMP (one cycle): on the edge leaving CMP, sample f_ref and f_min.
  - ref_table[vec] <= f_ref.
  - mismatch_mask[vec] <= f_ref ^ f_min.
  - On a mismatch, fail_count increments; if it was 0, first_fail <= vec.
  - If vec == 2**N_IN-1, go to DONE. Otherwise vec_out <= vec+1, counter <= 0, go to WAIT.
- Latency: each vector is held SETTLE+1 cycles. The last sample and the DONE entry occur at edge k + 2**N_IN*(SETTLE+1). Defaults give 16 cycles.
- DONE:
  - busy=0, done=1, equiv = (fail_count==0). All results are held stable; vec_out holds the last vector.
  - start=1 begins a new sweep exactly as from IDLE; done and equiv drop on that same edge.
- start while busy is ignored. It does not restart the sweep or extend it.
- vec_out wrap: the counter never wraps. Its terminal value is 2**N_IN-1.
- Width rule: fail_count saturates naturally, since at most 2**N_IN vectors fit in N_IN+1 bits. No overflow logic is needed.
- Reset during a sweep: all partial results are discarded, outputs go to 0 immediately, and the next start runs a complete sweep.
- f_ref and f_min are only sampled in CMP; glitches during WAIT are don't-care.

Decomposition:
- Shared package tt_check_pkg:
  - state enum {IDLE, WAIT, CMP, DONE};
  - localparam VEC_W = N_IN, TBL_W = 2**N_IN;
  - SETTLE_W = 4.
- One sub-module, tt_vec_sequencer: vector counter plus settle counter. It outputs vec_out and a one-cycle cmp_strobe. The top level holds the FSM and the result registers.

Test Plan:
1. Connect the existing 3-input SOP function (minterms 0,1,2,4,5) to f_ref and the AB+BC function to f_min; start with defaults. Required at edge k+16: done=1, ref_table=8'h37, mismatch_mask=8'hFF, fail_count=8, first_fail=0, equiv=0.
2. Tie f_min to f_ref. Required: ref_table=8'h37, mismatch_mask=8'h00, fail_count=0, equiv=1, done exactly 16 cycles after start.
3. f_min = f_ref XOR (vec_out==5). Required: mismatch_mask=8'h20, fail_count=1, first_fail=5, equiv=0.
4. Pulse start again at cycle 6 of a sweep: no effect, and done still asserts at k+16. Pulse start in DONE: done drops on the next edge and vec_out=0.
5. Assert rst asynchronously mid-cycle at cycle 7 of a sweep. Required: all outputs 0 before the next edge. After rst deasserts, a new start gives a full correct sweep (scenario 1 values).
6. SETTLE=3, N_IN=3, identical functions. Required: each vec_out value is held 4 cycles and done asserts at k+32.
